// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the shift-add multiplier controller
// Contents:
//   DEFAULT_WIDTH : default operand width / iteration count
//   COUNT_W       : width of the iteration counter for DEFAULT_WIDTH
//   state_e       : controller state encoding
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int COUNT_W       = $clog2(DEFAULT_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/mult_controller.sv
// rtl/mult_controller.sv - Moore FSM sequencing an external shift-add multiplier datapath
// Ports:
//   clk, reset          : clock; asynchronous active-high reset
//   start, abort, ack   : begin request, cancel of an operation in progress, done acknowledge
//   q0, count           : multiplier LSB and iteration count from the datapath/counter
//   load, add, shift    : datapath controls (mutually exclusive)
//   cnt_reset           : preset external counter to WIDTH-1
//   cnt_decrement       : decrement external counter
//   busy, done          : status; busy outside IDLE/DONE, done only in DONE
// WIDTH must be at least 2 so the count port has a non-zero width.
module mult_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     ack,
  input  logic                     q0,
  input  logic [$clog2(WIDTH)-1:0] count,
  output logic                     load,
  output logic                     add,
  output logic                     shift,
  output logic                     cnt_reset,
  output logic                     cnt_decrement,
  output logic                     busy,
  output logic                     done
);

  state_e state_q;
  state_e state_d;
  logic   in_op;
  logic   last_iter;

  // Operation in progress: the only states where abort has any effect.
  assign in_op     = (state_q == S_INIT) || (state_q == S_TEST) ||
                     (state_q == S_ADD)  || (state_q == S_SHIFT);
  assign last_iter = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_TEST;
      S_TEST:  state_d = q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = last_iter ? S_DONE : S_TEST;
      // start is deliberately not looked at here, even alongside ack.
      S_DONE:  if (ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Cancel overrides every other transition.
    if (abort && in_op) state_d = S_IDLE;
  end

  // Outputs decode from the state register only, so an asynchronous reset
  // clears them immediately.
  always_comb begin
    load          = 1'b0;
    add           = 1'b0;
    shift         = 1'b0;
    cnt_reset     = 1'b0;
    cnt_decrement = 1'b0;
    busy          = in_op;
    done          = 1'b0;
    case (state_q)
      S_INIT: begin
        load      = 1'b1;
        cnt_reset = 1'b1;
      end
      S_ADD:   add = 1'b1;
      S_SHIFT: begin
        shift         = 1'b1;
        // Hold the counter at zero on the final iteration so it never wraps.
        cnt_decrement = !last_iter;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
